// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: synchronises rx_pin, rebuilds LSB-first bytes, flags framing errors/overruns.
// Latency: data_ready rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk after the start edge (+/-1).
// Backpressure: none on the line; an unacked byte is overwritten by the next one and overrun pulses.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] data,
  output logic       data_ready,
  input  logic       data_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Last count of a full bit period, and of the half period that lands on mid start bit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Decoded sample points, produced by the output process.
  logic cnt_run;
  logic cnt_wrap;
  logic bit_tick;
  logic stop_good;
  logic stop_bad;

  // Two-flop synchroniser; resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_s    <= rx_meta;
    end
  end

  // State register; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: frame sequencing from the synchronised line only.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        // A high line at mid start bit was a glitch, not a frame.
        if (cnt == CNT_MID) state_nxt = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if ((cnt == CNT_LAST) && (bit_idx == 3'd7)) state_nxt = S_STOP;
      end
      S_STOP: begin
        // Leaving at mid stop bit gives half a bit of slack to catch a back-to-back start edge.
        if (cnt == CNT_LAST) state_nxt = rx_s ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: busy flag and the per-state sample strobes used by the datapath.
  always_comb begin
    busy      = (state != S_IDLE);
    cnt_run   = (state == S_START) || (state == S_DATA) || (state == S_STOP);
    cnt_wrap  = ((state == S_START) && (cnt == CNT_MID)) ||
                (((state == S_DATA) || (state == S_STOP)) && (cnt == CNT_LAST));
    bit_tick  = (state == S_DATA) && (cnt == CNT_LAST);
    stop_good = (state == S_STOP) && (cnt == CNT_LAST) && rx_s;
    stop_bad  = (state == S_STOP) && (cnt == CNT_LAST) && !rx_s;
  end

  // Bit-period counter: runs in timed states, restarts at each sample point, idles at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_run && !cnt_wrap) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Data bit index and shift register, filled LSB first at the middle of each data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else if (state != S_DATA) begin
      bit_idx <= 3'd0;
    end else if (bit_tick) begin
      shift[bit_idx] <= rx_s;
      bit_idx        <= bit_idx + 3'd1;
    end
  end

  // Output byte and ready/ack handshake; a completing byte takes priority over a same-cycle ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= 8'h00;
      data_ready <= 1'b0;
    end else if (stop_good) begin
      data       <= shift;
      data_ready <= 1'b1;
    end else if (data_ack) begin
      data_ready <= 1'b0;
    end
  end

  // Single-cycle error pulses; an ack in the completing cycle means the old byte was consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= stop_good && data_ready && !data_ack;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

  localparam int CPB = 8;

  logic       clk;
  logic       rst_n;
  logic       rx_pin;
  logic [7:0] data;
  logic       data_ready;
  logic       data_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  // Reference model state: what the receiver should be presenting.
  logic [7:0] exp_data;
  logic       exp_ready;
  int         exp_ferr;
  int         exp_ovr;
  logic [7:0] exp_q[$];

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_pin     (rx_pin),
    .data       (data),
    .data_ready (data_ready),
    .data_ack   (data_ack),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: one frame arrives; stop_ok says whether the stop bit was high, ack whether the
  // consumer acked in the same cycle the byte completes.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit ack);
    if (!stop_ok) begin
      exp_ferr++;
    end else begin
      if (exp_ready && !ack) exp_ovr++;
      exp_data  = b;
      exp_ready = 1'b1;
    end
  endtask

  task automatic model_ack();
    exp_ready = 1'b0;
  endtask

  task automatic model_reset();
    exp_data  = 8'h00;
    exp_ready = 1'b0;
  endtask

  // Serial transmitter: exactly CPB clocks per bit, transitions on falling clock edges.
  // Leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_pin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_pin = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_ready(input int max_cyc, output int n, output bit ok);
    n  = max_cyc;
    ok = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (data_ready) begin
        n  = k;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_ack();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  // Consumer: collects nbytes, acking each after a random delay, comparing with the model queue.
  task automatic consume(input int nbytes, input int max_delay);
    int  n;
    bit  ok;
    logic [7:0] want;
    for (int i = 0; i < nbytes; i++) begin
      wait_ready(400, n, ok);
      chk("rx_timeout", ok, 1'b1);
      if (!ok) break;
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      model_frame(want, 1'b1, 1'b0);
      chk("rx_byte", data, exp_data);
      repeat ($urandom_range(0, max_delay)) @(negedge clk);
      do_ack();
      model_ack();
    end
  endtask

  initial begin
    int  lat;
    bit  ok;
    bit  seen;
    string msg;
    logic [7:0] b;

    exp_data  = 8'h00;
    exp_ready = 1'b0;
    exp_ferr  = 0;
    exp_ovr   = 0;

    // Reset state.
    rst_n    = 1'b0;
    rx_pin   = 1'b1;
    data_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte with latency measurement.
    fork
      send_frame(8'h48, 1'b1);
      wait_ready(120, lat, ok);
    join
    chk("h_timeout", ok, 1'b1);
    chk("h_latency_78pm1", (lat >= 77) && (lat <= 79), 1'b1);
    model_frame(8'h48, 1'b1, 1'b0);
    chk("h_data", data, exp_data);
    chk("h_ready", data_ready, exp_ready);
    do_ack();
    model_ack();
    chk("h_ack_clears", data_ready, exp_ready);
    do_ack();
    chk("ack_idle_ignored", data_ready, exp_ready);

    // Short glitch on the line.
    rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    rx_pin = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < CPB; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("glitch_busy_clears", ok, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (data_ready) seen = 1'b1;
    end
    chk("glitch_no_ready", seen, exp_ready);

    // Framing error followed by a held-low break, then a good frame.
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    rx_pin = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    model_frame(8'h55, 1'b0, 1'b0);
    chk("ferr_count", ferr_cnt, exp_ferr);
    chk("ferr_ready", data_ready, exp_ready);
    chk("ferr_data_kept", data, exp_data);
    chk("ferr_ovr_none", ovr_cnt, exp_ovr);
    send_frame(8'h6C, 1'b1);
    repeat (4) @(negedge clk);
    model_frame(8'h6C, 1'b1, 1'b0);
    chk("post_ferr_data", data, exp_data);
    chk("post_ferr_ready", data_ready, exp_ready);
    do_ack();
    model_ack();

    // Back to back with no ack: overrun.
    send_frame(8'h48, 1'b1);
    send_frame(8'h65, 1'b1);
    repeat (4) @(negedge clk);
    model_frame(8'h48, 1'b1, 1'b0);
    model_frame(8'h65, 1'b1, 1'b0);
    chk("ovr_count", ovr_cnt, exp_ovr);
    chk("ovr_data", data, exp_data);
    chk("ovr_ready", data_ready, exp_ready);
    do_ack();
    model_ack();

    // Back to back with ack landing on the second byte's completion cycle:
    // second frame starts 10*CPB after the first; it completes 79 edges after its start.
    fork
      begin
        send_frame(8'h48, 1'b1);
        send_frame(8'h65, 1'b1);
      end
      begin
        repeat (10 * CPB + 78) @(negedge clk);
        chk("coinc_old_ready", data_ready, 1'b1);
        do_ack();
      end
    join
    repeat (4) @(negedge clk);
    model_frame(8'h48, 1'b1, 1'b0);
    model_frame(8'h65, 1'b1, 1'b1);
    chk("coinc_ovr_none", ovr_cnt, exp_ovr);
    chk("coinc_data", data, exp_data);
    chk("coinc_ready", data_ready, exp_ready);
    do_ack();
    model_ack();

    // Reset during bit 4, held until the line is idle again.
    fork
      send_frame(8'h6F, 1'b1);
      begin
        repeat (5 * CPB + 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
      end
    join
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2 * CPB) @(negedge clk);
    chk("midrst_ready", data_ready, exp_ready);
    chk("midrst_data", data, exp_data);

    // "Hello World " back to back, acked after each byte.
    msg = "Hello World ";
    fork
      for (int i = 0; i < msg.len(); i++) begin
        b = msg[i];
        exp_q.push_back(b);
        send_frame(b, 1'b1);
      end
      consume(msg.len(), 4);
    join
    repeat (4) @(negedge clk);
    chk("hello_ferr", ferr_cnt, exp_ferr);
    chk("hello_ovr", ovr_cnt, exp_ovr);
    chk("hello_ready", data_ready, exp_ready);

    // Random bytes with random idle gaps and random ack delay.
    exp_q.delete();
    fork
      for (int i = 0; i < 24; i++) begin
        logic [7:0] rb;
        rb = 8'($urandom_range(0, 255));
        exp_q.push_back(rb);
        send_frame(rb, 1'b1);
        rx_pin = 1'b1;
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      consume(24, 40);
    join
    repeat (4) @(negedge clk);
    chk("rand_ferr", ferr_cnt, exp_ferr);
    chk("rand_ovr", ovr_cnt, exp_ovr);
    chk("rand_ready", data_ready, exp_ready);
    chk("rand_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
